// File: rtl/uns_acc_frame.sv
// -----------------------------------------------------------------------------
// uns_acc_frame
//
// Framed unsigned accumulator. Each accepted sample adds a selectable operand
// (data1, data2 or data1+data2) into a wide accumulator. The accumulator either
// wraps or saturates on overflow, and it keeps a sticky overflow flag. When a
// non-zero frame length is programmed, the accumulator ends a frame after that
// many accepted samples. At frame end it latches the frame result and overflow
// flag, pulses o_valid for one cycle, and restarts from zero.
//
// Ports
//   clk       rising-edge clock
//   i_rst     synchronous active-high reset (clears every output)
//   i_data1   unsigned operand 1 (NB_DATA)
//   i_data2   unsigned operand 2 (NB_DATA)
//   i_sel     00 data1, 01 data2, 10 data1+data2, 11 hold (sample ignored)
//   i_valid   sample qualifier
//   i_clear   abort current frame; a sample in the same cycle is dropped
//   i_sat_en  1 saturate on overflow, 0 wrap modulo 2^NB_ACC
//   i_len     samples per frame, 0 = free-running (NB_LEN)
//   o_acc     running accumulator (NB_ACC)
//   o_ovf     sticky overflow of the current frame
//   o_count   accepted samples in the current frame (NB_LEN)
//   o_data    result of the last completed frame (NB_ACC)
//   o_carry   overflow flag of the last completed frame
//   o_valid   one-cycle strobe, o_data/o_carry just updated
// -----------------------------------------------------------------------------
module uns_acc_frame #(
   parameter int NB_DATA = 8,
   parameter int NB_ACC  = 16,
   parameter int NB_LEN  = 8
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic [NB_DATA-1:0] i_data1,
   input  logic [NB_DATA-1:0] i_data2,
   input  logic [1:0]        i_sel,
   input  logic              i_valid,
   input  logic              i_clear,
   input  logic              i_sat_en,
   input  logic [NB_LEN-1:0] i_len,
   output logic [NB_ACC-1:0] o_acc,
   output logic              o_ovf,
   output logic [NB_LEN-1:0] o_count,
   output logic [NB_ACC-1:0] o_data,
   output logic              o_carry,
   output logic              o_valid
);

   // Clamp to full scale on overflow when saturation is enabled, otherwise wrap.
   function automatic logic [NB_ACC-1:0] sat_fn(input logic [NB_ACC:0] s,
                                                input logic           en);
      if (s[NB_ACC] && en) sat_fn = {NB_ACC{1'b1}};
      else                 sat_fn = s[NB_ACC-1:0];
   endfunction

   logic [NB_ACC-1:0] acc_q,   acc_d;
   logic              ovf_q,   ovf_d;
   logic [NB_LEN-1:0] count_q, count_d;
   logic [NB_ACC-1:0] data_q,  data_d;
   logic              carry_q, carry_d;
   logic              valid_q, valid_d;

   logic [NB_DATA:0]  pair_sum;
   logic [NB_ACC:0]   operand;
   logic [NB_ACC:0]   sum;
   logic [NB_ACC-1:0] acc_new;
   logic              ovf_s;
   logic              accept;
   logic [NB_LEN:0]   cnt_inc;
   logic              frame_end;

   // data1+data2 keeps its carry bit, so the pair sum is never truncated.
   assign pair_sum = {1'b0, i_data1} + {1'b0, i_data2};

   always_comb begin
      operand = '0;
      case (i_sel)
         2'b00:   operand = {{(NB_ACC-NB_DATA+1){1'b0}}, i_data1};
         2'b01:   operand = {{(NB_ACC-NB_DATA+1){1'b0}}, i_data2};
         2'b10:   operand = {{(NB_ACC-NB_DATA){1'b0}}, pair_sum};
         default: operand = '0;
      endcase
   end

   assign accept  = i_valid && (i_sel != 2'b11);
   assign sum     = {1'b0, acc_q} + operand;
   assign ovf_s   = sum[NB_ACC];
   assign acc_new = sat_fn(sum, i_sat_en);

   // The count is compared one bit wider and with >=. A shrunk length then
   // still closes the frame, and a full-scale counter cannot wrap past i_len.
   assign cnt_inc   = {1'b0, count_q} + (NB_LEN+1)'(1);
   assign frame_end = accept && (i_len != '0) && (cnt_inc >= {1'b0, i_len});

   always_comb begin
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      data_d  = data_q;
      carry_d = carry_q;
      valid_d = 1'b0;
      if (i_clear) begin
         acc_d   = '0;
         ovf_d   = 1'b0;
         count_d = '0;
      end else if (frame_end) begin
         data_d  = acc_new;
         carry_d = ovf_q | ovf_s;
         valid_d = 1'b1;
         acc_d   = '0;
         ovf_d   = 1'b0;
         count_d = '0;
      end else if (accept) begin
         acc_d   = acc_new;
         ovf_d   = ovf_q | ovf_s;
         count_d = cnt_inc[NB_LEN-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         count_q <= '0;
         data_q  <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         valid_q <= valid_d;
      end
   end

   assign o_acc   = acc_q;
   assign o_ovf   = ovf_q;
   assign o_count = count_q;
   assign o_data  = data_q;
   assign o_carry = carry_q;
   assign o_valid = valid_q;

endmodule

// File: tb/tb_uns_acc_frame.sv
module tb_uns_acc_frame;

   logic       clk;
   logic       i_rst;
   logic [2:0] i_data1;
   logic [2:0] i_data2;
   logic [1:0] i_sel;
   logic       i_valid;
   logic       i_clear;
   logic       i_sat_en;
   logic [3:0] i_len;
   logic [5:0] o_acc;
   logic       o_ovf;
   logic [3:0] o_count;
   logic [5:0] o_data;
   logic       o_carry;
   logic       o_valid;

   int total;
   int passed;

   uns_acc_frame #(.NB_DATA(3), .NB_ACC(6), .NB_LEN(4)) dut (
      .clk(clk), .i_rst(i_rst), .i_data1(i_data1), .i_data2(i_data2),
      .i_sel(i_sel), .i_valid(i_valid), .i_clear(i_clear),
      .i_sat_en(i_sat_en), .i_len(i_len), .o_acc(o_acc), .o_ovf(o_ovf),
      .o_count(o_count), .o_data(o_data), .o_carry(o_carry), .o_valid(o_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      i_valid = 1'b0;
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i_data1  = 3'($urandom);
         i_data2  = 3'($urandom);
         i_sel    = 2'($urandom);
         i_valid  = 1'($urandom);
         i_clear  = 1'($urandom);
         i_sat_en = 1'($urandom);
         i_len    = 4'($urandom);
         step();
         total++;
         if (o_acc !== 6'd0 || o_ovf !== 1'b0 || o_count !== 4'd0 ||
             o_data !== 6'd0 || o_carry !== 1'b0 || o_valid !== 1'b0)
            $display("FAIL reset[%0d]: acc=%0d ovf=%b cnt=%0d data=%0d carry=%b vld=%b, expected all 0",
                     k, o_acc, o_ovf, o_count, o_data, o_carry, o_valid);
         else passed++;
      end
      i_rst = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_sat_en = 1'b0;
      i_len = 4'd0; i_sel = 2'b00;
   endtask

   task automatic test_frame();
      logic [5:0] exp_acc;
      i_len = 4'd4; i_data1 = 3'd1; i_data2 = 3'd2; i_valid = 1'b1;
      for (int f = 0; f < 2; f++) begin
         i_sel = (f == 0) ? 2'b00 : 2'b01;
         for (int k = 1; k <= 4; k++) begin
            step();
            exp_acc = (k == 4) ? 6'd0 : 6'(k * (f + 1));
            total++;
            if (o_acc !== exp_acc || o_count !== 4'(k % 4) || o_valid !== (k == 4))
               $display("FAIL frame%0d[%0d]: acc=%0d cnt=%0d vld=%b, expected acc=%0d cnt=%0d vld=%b",
                        f, k, o_acc, o_count, o_valid, exp_acc, k % 4, (k == 4));
            else passed++;
         end
         total++;
         if (o_data !== 6'(4 * (f + 1)) || o_carry !== 1'b0)
            $display("FAIL frame%0d_result: data=%0d carry=%b, expected data=%0d carry=0",
                     f, o_data, o_carry, 4 * (f + 1));
         else passed++;
      end
      i_valid = 1'b0;
      step();
      total++;
      if (o_valid !== 1'b0 || o_data !== 6'd8)
         $display("FAIL frame_hold: vld=%b data=%0d, expected vld=0 data=8", o_valid, o_data);
      else passed++;
   endtask

   task automatic test_overflow();
      for (int s = 0; s < 2; s++) begin
         i_len = 4'd0; i_sel = 2'b10; i_data1 = 3'd1; i_data2 = 3'd2;
         i_sat_en = 1'b0;
         do_clear();
         i_valid = 1'b1;
         for (int k = 0; k < 21; k++) step();
         total++;
         if (o_acc !== 6'd63 || o_ovf !== 1'b0 || o_count !== 4'd5)
            $display("FAIL ovf%0d_pre: acc=%0d ovf=%b cnt=%0d, expected acc=63 ovf=0 cnt=5",
                     s, o_acc, o_ovf, o_count);
         else passed++;
         i_sat_en = (s == 1);
         step();
         total++;
         if (o_acc !== ((s == 1) ? 6'd63 : 6'd2) || o_ovf !== 1'b1 || o_count !== 4'd6 ||
             o_valid !== 1'b0)
            $display("FAIL ovf%0d_post: acc=%0d ovf=%b cnt=%0d vld=%b, expected acc=%0d ovf=1 cnt=6 vld=0",
                     s, o_acc, o_ovf, o_count, o_valid, (s == 1) ? 63 : 2);
         else passed++;
      end
      // free-running counter wraps modulo 16
      for (int k = 0; k < 10; k++) step();
      total++;
      if (o_count !== 4'd0 || o_acc !== 6'd63 || o_ovf !== 1'b1)
         $display("FAIL ovf_wrap: cnt=%0d acc=%0d ovf=%b, expected cnt=0 acc=63 ovf=1",
                  o_count, o_acc, o_ovf);
      else passed++;
      i_valid = 1'b0;
   endtask

   task automatic test_hold();
      i_sat_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         i_sel   = (k % 2 == 0) ? 2'b11 : 2'b00;
         i_valid = (k % 2 == 0);
         step();
         total++;
         if (o_acc !== 6'd63 || o_count !== 4'd0 || o_ovf !== 1'b1)
            $display("FAIL hold[%0d]: acc=%0d cnt=%0d ovf=%b, expected acc=63 cnt=0 ovf=1",
                     k, o_acc, o_count, o_ovf);
         else passed++;
      end
      i_valid = 1'b0;
   endtask

   task automatic test_clear();
      i_len = 4'd4;
      do_clear();
      total++;
      if (o_acc !== 6'd0 || o_count !== 4'd0 || o_ovf !== 1'b0)
         $display("FAIL clear_idle: acc=%0d cnt=%0d ovf=%b, expected 0 0 0", o_acc, o_count, o_ovf);
      else passed++;
      i_sel = 2'b00; i_data1 = 3'd7; i_valid = 1'b1;
      step(); step();
      total++;
      if (o_acc !== 6'd14 || o_count !== 4'd2)
         $display("FAIL clear_pre: acc=%0d cnt=%0d, expected acc=14 cnt=2", o_acc, o_count);
      else passed++;
      i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      total++;
      if (o_acc !== 6'd0 || o_count !== 4'd0 || o_valid !== 1'b0 || o_data !== 6'd8)
         $display("FAIL clear_drop: acc=%0d cnt=%0d vld=%b data=%0d, expected acc=0 cnt=0 vld=0 data=8",
                  o_acc, o_count, o_valid, o_data);
      else passed++;
      for (int k = 0; k < 4; k++) step();
      total++;
      if (o_valid !== 1'b1 || o_data !== 6'd28 || o_carry !== 1'b0 || o_acc !== 6'd0)
         $display("FAIL clear_frame: vld=%b data=%0d carry=%b acc=%0d, expected vld=1 data=28 carry=0 acc=0",
                  o_valid, o_data, o_carry, o_acc);
      else passed++;
      i_valid = 1'b0;
   endtask

   task automatic test_carry();
      // 14 per sample, len 6: 14,28,42,56, then wrap to 6 (ovf), 20 closes frame
      i_len = 4'd6; i_sel = 2'b10; i_data1 = 3'd7; i_data2 = 3'd7; i_sat_en = 1'b0;
      i_valid = 1'b1;
      for (int k = 0; k < 5; k++) step();
      total++;
      if (o_acc !== 6'd6 || o_ovf !== 1'b1 || o_valid !== 1'b0)
         $display("FAIL carry_mid: acc=%0d ovf=%b vld=%b, expected acc=6 ovf=1 vld=0", o_acc, o_ovf, o_valid);
      else passed++;
      step();
      total++;
      if (o_valid !== 1'b1 || o_data !== 6'd20 || o_carry !== 1'b1 || o_ovf !== 1'b0)
         $display("FAIL carry_end: vld=%b data=%0d carry=%b ovf=%b, expected vld=1 data=20 carry=1 ovf=0",
                  o_valid, o_data, o_carry, o_ovf);
      else passed++;
      i_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      i_len = 4'd1; i_sel = 2'b00; i_data1 = 3'd5; i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (o_valid !== 1'b1 || o_data !== 6'd5 || o_carry !== 1'b0 || o_acc !== 6'd0 ||
             o_count !== 4'd0)
            $display("FAIL b2b[%0d]: vld=%b data=%0d carry=%b acc=%0d cnt=%0d, expected vld=1 data=5 carry=0 acc=0 cnt=0",
                     k, o_valid, o_data, o_carry, o_acc, o_count);
         else passed++;
      end
      i_valid = 1'b0;
      step();
   endtask

   task automatic test_len_change_reset();
      i_len = 4'd8; i_sel = 2'b00; i_data1 = 3'd1; i_valid = 1'b1;
      for (int k = 0; k < 5; k++) step();
      total++;
      if (o_acc !== 6'd5 || o_count !== 4'd5 || o_valid !== 1'b0)
         $display("FAIL len_pre: acc=%0d cnt=%0d vld=%b, expected acc=5 cnt=5 vld=0", o_acc, o_count, o_valid);
      else passed++;
      i_len = 4'd3;
      step();
      total++;
      if (o_valid !== 1'b1 || o_data !== 6'd6 || o_acc !== 6'd0 || o_count !== 4'd0)
         $display("FAIL len_shrink: vld=%b data=%0d acc=%0d cnt=%0d, expected vld=1 data=6 acc=0 cnt=0",
                  o_valid, o_data, o_acc, o_count);
      else passed++;
      step(); step();
      total++;
      if (o_acc !== 6'd2 || o_count !== 4'd2 || o_valid !== 1'b0)
         $display("FAIL len_partial: acc=%0d cnt=%0d vld=%b, expected acc=2 cnt=2 vld=0", o_acc, o_count, o_valid);
      else passed++;
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      i_valid = 1'b0;
      total++;
      if (o_valid !== 1'b0 || o_acc !== 6'd0 || o_count !== 4'd0 || o_data !== 6'd0)
         $display("FAIL len_reset: vld=%b acc=%0d cnt=%0d data=%0d, expected all 0",
                  o_valid, o_acc, o_count, o_data);
      else passed++;
      step();
      total++;
      if (o_valid !== 1'b0 || o_acc !== 6'd0)
         $display("FAIL len_after_reset: vld=%b acc=%0d, expected vld=0 acc=0", o_valid, o_acc);
      else passed++;
   endtask

   initial begin
      total = 0; passed = 0;
      i_rst = 1'b1; i_data1 = '0; i_data2 = '0; i_sel = '0; i_valid = 1'b0;
      i_clear = 1'b0; i_sat_en = 1'b0; i_len = '0;
      test_reset();
      test_frame();
      test_overflow();
      test_hold();
      test_clear();
      test_carry();
      test_back_to_back();
      test_len_change_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
